lab03_btn_ctrl: RTL and testbench

Upstream control stage for the LED rotator. It turns three raw push-buttons into clean control levels `en` and `dir` and a one-cycle `clr_pulse`. Each button passes through a synchroniser, a sampled debouncer and a one-pulse edge detector. A two-state run FSM and a direction toggle drive the rotator's `en`/`dir` inputs; `clr_pulse` drives its reset-to-start input.

---
 rtl/lab03_btn_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_lab03_btn_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab03_btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lab03_btn_ctrl
//  Purpose  : Upstream control stage for the LED rotator. Three raw, bouncy
//             push-buttons are synchronised, debounced on a slow sample tick
//             and edge-detected. The resulting one-clk presses drive a
//             STOP/RUN FSM (en), a direction toggle (dir) and a clear
//             request (clr_pulse).
//  Ports    : clk        system clock
//             rst        synchronous reset, active-low
//             btn_en     raw run/stop button (asynchronous)
//             btn_dir    raw direction button (asynchronous)
//             btn_clr    raw clear button (asynchronous)
//             en         rotator enable level (1 = RUN)
//             dir        rotator direction level
//             clr_pulse  one-clk clear request
//             en_pulse   one-clk pulse per accepted run/stop press
//  Options  : LONG_PRESS_CLR_EN - holding btn_en for LONG_TICKS sample ticks
//             issues a clear, once per hold.
//  Revision : 1.0 - initial release
// ============================================================================
module lab03_btn_ctrl #(
    parameter int DEB_LEN    = 4,
    parameter int SAMPLE_DIV = 16,
    parameter bit DIR_INIT   = 1'b1,
    parameter int LONG_TICKS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_en,
    input  logic btn_dir,
    input  logic btn_clr,
    output logic en,
    output logic dir,
    output logic clr_pulse,
    output logic en_pulse
);

    localparam int                 c_CNT_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SAMPLE_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [0:0] c_ST_STOP = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Bit order for all per-button vectors: [0]=en, [1]=dir, [2]=clr
    logic [2:0]         w_btn_raw;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [c_CNT_W-1:0] r_sample_cnt;
    logic               w_tick;
    logic [DEB_LEN-1:0] r_shift     [3];
    logic [DEB_LEN-1:0] w_shift_nxt [3];
    logic [2:0]         r_level;
    logic [2:0]         w_level_nxt;
    logic [2:0]         r_level_d;
    logic [2:0]         w_press;
    logic               w_long_clr;
    logic               w_clr;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               r_dir;
    logic               r_clr_pulse;
    logic               r_en_pulse;

    assign w_btn_raw = {btn_clr, btn_dir, btn_en};

    // Two-flop synchroniser per button
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running sample divider
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sample_cnt <= '0;
        end else if (r_sample_cnt == c_CNT_MAX) begin
            r_sample_cnt <= '0;
        end else begin
            r_sample_cnt <= r_sample_cnt + c_CNT_ONE;
        end
    end

    assign w_tick = (r_sample_cnt == c_CNT_MAX);

    // The debounced level is judged on the post-shift value so it moves on
    // the same edge that the completing sample enters the register.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_shift_nxt[i] = r_shift[i];
            w_level_nxt[i] = r_level[i];
            if (w_tick) begin
                w_shift_nxt[i] = {r_shift[i][DEB_LEN-2:0], r_sync2[i]};
            end
            if (&w_shift_nxt[i]) begin
                w_level_nxt[i] = 1'b1;
            end else if (~|w_shift_nxt[i]) begin
                w_level_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                r_shift[i] <= '0;
            end
            r_level   <= '0;
            r_level_d <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_shift[i] <= w_shift_nxt[i];
            end
            r_level   <= w_level_nxt;
            r_level_d <= r_level;
        end
    end

    // One clk per debounced rising edge; releases are ignored
    assign w_press = r_level & ~r_level_d;

`ifdef LONG_PRESS_CLR_EN
    localparam int                  c_HOLD_W    = $clog2(LONG_TICKS + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(LONG_TICKS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_TICKS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    logic [c_HOLD_W-1:0] r_hold_cnt;

    // Saturating hold counter; saturation is what limits the clear to one per hold
    always_ff @(posedge clk) begin
        if (!rst || !r_level[0]) begin
            r_hold_cnt <= '0;
        end else if (w_tick && (r_hold_cnt != c_HOLD_MAX)) begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
        end
    end

    // Fires on the tick that brings the counter to LONG_TICKS
    assign w_long_clr = w_tick & r_level[0] & (r_hold_cnt == c_HOLD_LAST);
`else
    logic [31:0] w_unused_long_ticks;

    assign w_unused_long_ticks = LONG_TICKS;
    assign w_long_clr          = 1'b0;
`endif

    assign w_clr = w_press[2] | w_long_clr;

    // Run FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run FSM: next state; a clear overrides a coincident run/stop press
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = c_ST_STOP;
        end else if (w_press[0]) begin
            case (r_state)
                c_ST_STOP: w_state_nxt = c_ST_RUN;
                c_ST_RUN:  w_state_nxt = c_ST_STOP;
                default:   w_state_nxt = c_ST_STOP;
            endcase
        end
    end

    // Run FSM: output
    always_comb begin
        en = (r_state == c_ST_RUN);
    end

    // Direction toggle and registered pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dir       <= DIR_INIT;
            r_clr_pulse <= 1'b0;
            r_en_pulse  <= 1'b0;
        end else begin
            r_clr_pulse <= w_clr;
            r_en_pulse  <= w_press[0] & ~w_clr;
            if (w_clr) begin
                r_dir <= DIR_INIT;
            end else if (w_press[1]) begin
                r_dir <= ~r_dir;
            end
        end
    end

    assign dir       = r_dir;
    assign clr_pulse = r_clr_pulse;
    assign en_pulse  = r_en_pulse;

endmodule
`default_nettype wire

// File: tb/tb_lab03_btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab03_btn_ctrl
//  Purpose  : Self-checking bench for lab03_btn_ctrl. Expected output events
//             {en_pulse, clr_pulse, en, dir} are queued as stimulus is
//             driven and matched when the DUT outputs change or pulse.
//             With LONG_PRESS_CLR_EN defined, a third instance exercises the
//             long-hold clear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lab03_btn_ctrl;

    localparam int c_DEB = 3;
    localparam int c_DIV = 2;

    typedef struct {
        string      tag;
        logic [3:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_en = 1'b0;
    logic btn_dir = 1'b0;
    logic btn_clr = 1'b0;
    logic en, dir, clr_pulse, en_pulse;
    logic en5, dir5, clr5, enp5;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_on   = 1'b0;
    logic m_en, m_dir;
    logic prev_en, prev_dir;

    always #5 clk = ~clk;

    lab03_btn_ctrl #(.DEB_LEN(c_DEB), .SAMPLE_DIV(c_DIV), .DIR_INIT(1'b1), .LONG_TICKS(64)) dut (
        .clk(clk), .rst(rst), .btn_en(btn_en), .btn_dir(btn_dir), .btn_clr(btn_clr),
        .en(en), .dir(dir), .clr_pulse(clr_pulse), .en_pulse(en_pulse)
    );

    lab03_btn_ctrl #(.DEB_LEN(c_DEB), .SAMPLE_DIV(5), .DIR_INIT(1'b1), .LONG_TICKS(64)) dut_div5 (
        .clk(clk), .rst(rst), .btn_en(1'b0), .btn_dir(1'b0), .btn_clr(1'b0),
        .en(en5), .dir(dir5), .clr_pulse(clr5), .en_pulse(enp5)
    );

`ifdef LONG_PRESS_CLR_EN
    logic lp_btn = 1'b0;
    logic lp_en, lp_dir, lp_clr, lp_enp;
    int   lp_n_enp = 0;
    int   lp_n_clr = 0;
    bit   lp_saw_en = 1'b0;

    lab03_btn_ctrl #(.DEB_LEN(c_DEB), .SAMPLE_DIV(c_DIV), .DIR_INIT(1'b1), .LONG_TICKS(4)) dut_lp (
        .clk(clk), .rst(rst), .btn_en(lp_btn), .btn_dir(1'b0), .btn_clr(1'b0),
        .en(lp_en), .dir(lp_dir), .clr_pulse(lp_clr), .en_pulse(lp_enp)
    );

    always @(negedge clk) begin
        if (mon_on) begin
            if (lp_enp) lp_n_enp++;
            if (lp_clr) lp_n_clr++;
            if (lp_en)  lp_saw_en = 1'b1;
        end
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: any pulse or level change is an output event
    always @(negedge clk) begin
        if (mon_on) begin
            if (en_pulse || clr_pulse || (en !== prev_en) || (dir !== prev_dir)) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event_queue_size", 32'(sb_q.size()), 32'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk(mon_e.tag, {28'd0, en_pulse, clr_pulse, en, dir}, {28'd0, mon_e.v});
                end
            end
            prev_en  = en;
            prev_dir = dir;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Update the reference state for an accepted press and queue the event
    task automatic expect_act(input string tag, input bit p_en, input bit p_dir, input bit p_clr);
        exp_t e;
        logic ep;
        if (p_clr) begin
            ep    = 1'b0;
            m_en  = 1'b0;
            m_dir = 1'b1;
        end else begin
            ep = p_en;
            if (p_en)  m_en  = ~m_en;
            if (p_dir) m_dir = ~m_dir;
        end
        e.tag = tag;
        e.v   = {ep, p_clr, m_en, m_dir};
        sb_q.push_back(e);
    endtask

    task automatic wait_empty(input string tag, input int max, output int n);
        n = 0;
        while ((sb_q.size() != 0) && (n < max)) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int n;
        int m_cnt;
        exp_t e;

        // Reset state
        cyc(3);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_en", 32'(en), 32'd0);
        chk("reset_dir", 32'(dir), 32'd1);
        chk("reset_clr_pulse", 32'(clr_pulse), 32'd0);
        chk("reset_en_pulse", 32'(en_pulse), 32'd0);
        m_en     = 1'b0;
        m_dir    = 1'b1;
        prev_en  = en;
        prev_dir = dir;
        mon_on   = 1'b1;

        // Sample counter wrap on the SAMPLE_DIV=5 instance
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        m_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("div5_counter", 32'(dut_div5.r_sample_cnt), 32'(m_cnt));
            chk("div5_tick", 32'(dut_div5.w_tick), 32'(m_cnt == 4));
            m_cnt = (m_cnt == 4) ? 0 : m_cnt + 1;
        end

        // Clean press, hold, release, second press
        cyc(1);
        expect_act("en_press1", 1'b1, 1'b0, 1'b0);
        btn_en = 1'b1;
        wait_empty("en_press1_seen", 40, n);
        chk("en_press1_latency_ok", 32'((n - 1) <= (2 + 2 * c_DEB + 2)), 32'd1);
        cyc(30 - n);
        btn_en = 1'b0;
        cyc(20);
        chk("en_after_release", 32'(en), 32'd1);
        expect_act("en_press2", 1'b1, 1'b0, 1'b0);
        btn_en = 1'b1;
        wait_empty("en_press2_seen", 40, n);
        cyc(10);
        btn_en = 1'b0;
        cyc(20);
        chk("en_after_press2", 32'(en), 32'd0);

        // Bounce at the sample rate: successive samples alternate, so no
        // DEB_LEN-long run forms until the input settles.
        for (int i = 0; i < 8; i++) begin
            btn_dir = (i % 2 == 0);
            cyc(c_DIV);
        end
        cyc(20);
        chk("bounce_low_dir", 32'(dir), 32'd1);
        expect_act("bounce_high_flip", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            btn_dir = (i % 2 == 1);
            cyc(c_DIV);
        end
        wait_empty("bounce_high_seen", 40, n);
        cyc(10);
        btn_dir = 1'b0;
        cyc(20);
        chk("bounce_high_dir", 32'(dir), 32'd0);

        // Clear beats a coincident run/stop press
        expect_act("en_press3", 1'b1, 1'b0, 1'b0);
        btn_en = 1'b1;
        wait_empty("en_press3_seen", 40, n);
        cyc(5);
        btn_en = 1'b0;
        cyc(20);
        expect_act("clear_priority", 1'b1, 1'b0, 1'b1);
        btn_en  = 1'b1;
        btn_clr = 1'b1;
        wait_empty("clear_priority_seen", 40, n);
        cyc(10);
        btn_en  = 1'b0;
        btn_clr = 1'b0;
        cyc(20);
        chk("clear_en", 32'(en), 32'd0);
        chk("clear_dir", 32'(dir), 32'd1);

        // Reset mid-operation with btn_dir partly debounced
        expect_act("en_press4", 1'b1, 1'b0, 1'b0);
        btn_en = 1'b1;
        wait_empty("en_press4_seen", 40, n);
        cyc(5);
        btn_en = 1'b0;
        cyc(20);
        expect_act("dir_press", 1'b0, 1'b1, 1'b0);
        btn_dir = 1'b1;
        wait_empty("dir_press_seen", 40, n);
        cyc(5);
        btn_dir = 1'b0;
        cyc(20);
        btn_dir = 1'b1;
        cyc(5);
        e.tag = "reset_mid";
        e.v   = 4'b0001;
        sb_q.push_back(e);
        m_en  = 1'b0;
        m_dir = 1'b1;
        rst   = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_en", 32'(en), 32'd0);
        chk("reset_mid_dir", 32'(dir), 32'd1);
        chk("reset_mid_pulses", {30'd0, clr_pulse, en_pulse}, 32'd0);
        expect_act("dir_after_reset", 1'b0, 1'b1, 1'b0);
        wait_empty("dir_after_reset_seen", 40, n);
        chk("dir_after_reset_full_debounce", 32'((n - 1) >= (2 + 2 * c_DEB)), 32'd1);
        cyc(5);
        btn_dir = 1'b0;
        cyc(20);

        // Simultaneous run/stop and direction presses
        expect_act("en_dir_same_edge", 1'b1, 1'b1, 1'b0);
        btn_en  = 1'b1;
        btn_dir = 1'b1;
        wait_empty("en_dir_same_edge_seen", 40, n);
        cyc(5);
        btn_en  = 1'b0;
        btn_dir = 1'b0;
        cyc(20);
        chk("final_en", 32'(en), 32'd1);
        chk("final_dir", 32'(dir), 32'd1);

`ifdef LONG_PRESS_CLR_EN
        // Long hold: toggle to RUN, then one clear back to STOP
        lp_btn = 1'b1;
        cyc(40);
        chk("lp1_en_pulses", 32'(lp_n_enp), 32'd1);
        chk("lp1_clr_pulses", 32'(lp_n_clr), 32'd1);
        chk("lp1_saw_run", 32'(lp_saw_en), 32'd1);
        chk("lp1_en_final", 32'(lp_en), 32'd0);
        cyc(20);
        chk("lp1_still_one_clr", 32'(lp_n_clr), 32'd1);
        lp_btn = 1'b0;
        cyc(20);
        lp_saw_en = 1'b0;
        lp_btn = 1'b1;
        cyc(40);
        chk("lp2_en_pulses", 32'(lp_n_enp), 32'd2);
        chk("lp2_clr_pulses", 32'(lp_n_clr), 32'd2);
        chk("lp2_saw_run", 32'(lp_saw_en), 32'd1);
        chk("lp2_en_final", 32'(lp_en), 32'd0);
        lp_btn = 1'b0;
        cyc(20);
`endif

        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
